// File: rtl/instruction_fetcher.sv
// Fetch stage: assembles little-endian 32-bit instructions from a byte-wide memory
// and hands them to decode over a valid/ready handshake, honouring redirects and bus stalls.
module instruction_fetcher #(
  parameter int             LEN      = 32,
  parameter logic [LEN-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy_in,
  input  logic [7:0]     mem_din,
  output logic [LEN-1:0] mem_a,
  output logic           mem_rd,
  input  logic           mem_busy,
  input  logic           redirect_valid,
  input  logic [LEN-1:0] redirect_pc,
  output logic           inst_valid,
  input  logic           inst_ready,
  output logic [LEN-1:0] instruction,
  output logic [LEN-1:0] inst_pc
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [LEN-1:0] pc_q, pc_d;
  logic [2:0]     issue_cnt_q, issue_cnt_d;
  logic [2:0]     recv_cnt_q, recv_cnt_d;
  logic           pending_q, pending_d;
  logic           inst_valid_q, inst_valid_d;
  logic [LEN-1:0] instruction_q, instruction_d;
  logic [LEN-1:0] inst_pc_q, inst_pc_d;

  assign mem_a = pc_q + LEN'(issue_cnt_q);
  assign mem_rd = !rst && rdy_in && !mem_busy && !redirect_valid &&
                  (state_q == FETCH) && (issue_cnt_q < 3'd4);

  assign inst_valid  = inst_valid_q;
  assign instruction = instruction_q;
  assign inst_pc     = inst_pc_q;

  // Redirect outranks everything, including an accept in the same cycle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    issue_cnt_d   = issue_cnt_q;
    recv_cnt_d    = recv_cnt_q;
    pending_d     = pending_q;
    inst_valid_d  = inst_valid_q;
    instruction_d = instruction_q;
    inst_pc_d     = inst_pc_q;

    if (rdy_in) begin
      if (redirect_valid) begin
        pc_d         = {redirect_pc[LEN-1:2], 2'b00};
        issue_cnt_d  = 3'd0;
        recv_cnt_d   = 3'd0;
        pending_d    = 1'b0;
        inst_valid_d = 1'b0;
        state_d      = FETCH;
      end else begin
        pending_d = mem_rd;
        if (mem_rd) begin
          issue_cnt_d = issue_cnt_q + 3'd1;
        end
        if (pending_q) begin
          instruction_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_din;
          recv_cnt_d = recv_cnt_q + 3'd1;
          if (recv_cnt_q == 3'd3) begin
            state_d      = HOLD;
            inst_valid_d = 1'b1;
            inst_pc_d    = pc_q;
          end
        end
        // No prefetch: the next instruction starts only after decode takes this one.
        if ((state_q == HOLD) && inst_valid_q && inst_ready) begin
          pc_d         = pc_q + LEN'(4);
          issue_cnt_d  = 3'd0;
          recv_cnt_d   = 3'd0;
          pending_d    = 1'b0;
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      issue_cnt_q   <= 3'd0;
      recv_cnt_q    <= 3'd0;
      pending_q     <= 1'b0;
      inst_valid_q  <= 1'b0;
      instruction_q <= '0;
      inst_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      issue_cnt_q   <= issue_cnt_d;
      recv_cnt_q    <= recv_cnt_d;
      pending_q     <= pending_d;
      inst_valid_q  <= inst_valid_d;
      instruction_q <= instruction_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

endmodule
